// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, response codes, FSM states.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_SIZE     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_e;

    // Natural alignment: the low 'size' address bits must be zero.
    function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size);
        case (size)
            SIZE_B:  misaligned = 1'b0;
            SIZE_H:  misaligned = lo[0];
            SIZE_W:  misaligned = |lo[1:0];
            default: misaligned = |lo[2:0];
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane steering for stores and shift/extend for loads.
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN/8)
) (
    input  logic [OFF_W-1:0]  i_off,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN-1:0]   i_drdata,
    output logic [XLEN/8-1:0] o_dbe,
    output logic [XLEN-1:0]   o_dwdata,
    output logic [XLEN-1:0]   o_rdata
);
    localparam int NB = XLEN/8;

    logic [NB-1:0]   w_lenmask;
    logic [XLEN-1:0] w_lanemask;
    logic [XLEN-1:0] w_raw;
    logic            w_sign;
    int              w_nbits;

    always_comb begin
        w_lenmask  = '0;
        w_lanemask = '0;
        o_rdata    = '0;
        for (int i = 0; i < NB; i++)
            w_lenmask[i] = (i < (1 << i_size));
        o_dbe = w_lenmask << i_off;
        for (int i = 0; i < XLEN; i++)
            w_lanemask[i] = o_dbe[i/8];
        o_dwdata = (i_wdata << {i_off, 3'b000}) & w_lanemask;

        w_raw   = i_drdata >> {i_off, 3'b000};
        w_nbits = 8 << i_size;
        case (i_size)
            SIZE_B:  w_sign = w_raw[7];
            SIZE_H:  w_sign = w_raw[15];
            SIZE_W:  w_sign = w_raw[31];
            default: w_sign = w_raw[XLEN-1];
        endcase
        // A full-width load has no bits left to extend, so unsigned is moot there.
        w_sign = w_sign & ~i_unsigned;
        for (int i = 0; i < XLEN; i++)
            o_rdata[i] = (i < w_nbits) ? w_raw[i] : w_sign;
    end

endmodule

// File: rtl/rv_lsu.sv
// Registered, handshaked load/store engine between execute and the data bus.
module rv_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              busy,
    output logic              dreq,
    output logic              dwrite,
    output logic [1:0]        dsize,
    output logic [XLEN-1:0]   daddr,
    output logic [XLEN/8-1:0] dbe,
    output logic [XLEN-1:0]   dwdata,
    input  logic [XLEN-1:0]   drdata,
    input  logic              dready_n,
    input  logic              dbusy
);
    localparam int OFF_W = $clog2(XLEN/8);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OFF_W-1:0] r_off;
    logic [1:0]       r_size;
    logic             r_unsigned;

    logic [OFF_W-1:0]  w_off;
    logic [1:0]        w_size;
    logic              w_unsigned;
    logic [XLEN/8-1:0] w_dbe;
    logic [XLEN-1:0]   w_dwdata;
    logic [XLEN-1:0]   w_rdata;
    logic              w_bad_size;
    logic              w_misalign;
    logic              w_done;
    logic              w_timeout;

    // One lane instance serves both phases: request fields in IDLE, latched fields on the bus.
    assign w_off      = (r_state == S_IDLE) ? req_addr[OFF_W-1:0] : r_off;
    assign w_size     = (r_state == S_IDLE) ? req_size : r_size;
    assign w_unsigned = (r_state == S_IDLE) ? req_unsigned : r_unsigned;

    lsu_lane #(.XLEN(XLEN)) u_lane (
        .i_off      (w_off),
        .i_size     (w_size),
        .i_unsigned (w_unsigned),
        .i_wdata    (req_wdata),
        .i_drdata   (drdata),
        .o_dbe      (w_dbe),
        .o_dwdata   (w_dwdata),
        .o_rdata    (w_rdata)
    );

    assign w_bad_size = (req_size == SIZE_D) && (XLEN == 32);
    assign w_misalign = misaligned(req_addr[2:0], req_size);
    assign w_done     = dwrite ? ~dbusy : ~dready_n;
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_off      <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
            busy       <= 1'b0;
            dreq       <= 1'b0;
            dwrite     <= 1'b0;
            dsize      <= '0;
            daddr      <= '0;
            dbe        <= '0;
            dwdata     <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_off      <= req_addr[OFF_W-1:0];
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        dwrite     <= req_write;
                        dsize      <= req_size;
                        daddr      <= req_addr;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        if (w_bad_size || w_misalign) begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= w_bad_size ? ERR_SIZE : ERR_MISALIGN;
                        end else begin
                            r_state <= S_BUS;
                            r_cnt   <= '0;
                            dreq    <= 1'b1;
                            dbe     <= w_dbe;
                            dwdata  <= w_dwdata;
                        end
                    end
                end
                S_BUS: begin
                    if (w_done) begin
                        r_state    <= S_RESP;
                        dreq       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= dwrite ? '0 : w_rdata;
                    end else if (w_timeout) begin
                        r_state    <= S_RESP;
                        dreq       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
